mux_rr_nto1: RTL and testbench
==============================

// Module: mux_rr_nto1
// PURPOSE
// Parametrised N-to-1 registered multiplexer with valid/ready handshake on every port.
// When several inputs hold data, an internal arbiter picks one: round-robin or fixed priority.
// The winner goes into a one-deep output register, so each beat appears one cycle after it is accepted.
// Use it where several producers share one consumer.
// PARAMETERS
// N      4  number of input channels, N >= 2
// WIDTH  8  data width per channel, in bits
// MODE   0  0 = round-robin; 1 = fixed priority, lowest index wins
// SEL_W  $clog2(N)  width of the channel index (derived, do not override)
// PORTS
// clk        in   1        rising-edge clock
// rst        in   1        synchronous reset, active-high
// in_valid   in   N        per-channel valid; bit i belongs to channel i
// in_data    in   N*WIDTH  channel i data at [i*WIDTH +: WIDTH]
// in_ready   out  N        per-channel accept; at most one bit high per cycle
// out_valid  out  1        output register holds a beat
// out_data   out  WIDTH    registered data of the granted channel
// out_sel    out  SEL_W    index of the channel that produced out_data
// out_ready  in   1        consumer accepts the beat when out_valid && out_ready
// BEHAVIOUR
// - Reset: synchronous, applied at the clk edge while rst=1.
//   Sets out_valid=0, out_data=0, out_sel=0 and rr_ptr=0.
//   Any beat held in the output register is dropped; no input is accepted while rst=1.
// - Load condition: load = !out_valid || out_ready (register empty, or draining this cycle).
// - Grant, combinational:
//   - MODE=0: first i with in_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... and wrapping mod N.
//   - MODE=1: lowest i with in_valid[i]=1.
//   - If no in_valid bit is set, there is no grant.
// - in_ready[i] = load && grant==i && !rst. It is combinational from in_valid, out_valid, out_ready and rr_ptr.
// - Transfer on channel i: in_valid[i] && in_ready[i] at a clk edge. Then:
//   - out_data <= channel i data, out_sel <= i, out_valid <= 1;
//   - MODE=0 only: rr_ptr <= (i==N-1) ? 0 : i+1.
// - Load with no grant: out_valid <= 0; out_data and out_sel hold their last values.
// - Stall (out_valid && !out_ready):
//   - out_valid, out_data and out_sel hold;
//   - all in_ready=0 and rr_ptr holds.
// - Full throughput: one beat per cycle when out_ready stays 1. Latency from input transfer to out_valid is 1 cycle.
// - Simultaneous drain and refill: the new beat replaces the consumed one in the same edge, with no bubble.
// - Fairness (MODE=0): with all N channels valid continuously, each channel is granted exactly once in every N consecutive transfers.
// - Channel order is kept per channel. Inputs must hold in_valid and in_data stable until accepted; the bench checks this, the RTL does not.
// - rr_ptr is SEL_W bits wide and only ever holds 0..N-1. This also holds for N that is not a power of 2.
// TESTING  (N=4, WIDTH=8 unless stated)
// 1. Reset:
//    - rst=1 for 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, out_sel=0, in_ready=0000.
//    - After release, the first grant goes to channel 0.
// 2. Single channel: in_valid=0100, data=8'hA5, out_ready=1 -> in_ready=0100.
//    The next cycle shows out_valid=1, out_data=A5, out_sel=2.
// 3. Round-robin, MODE=0: all valid, ch i data=8'h10+i, out_ready=1 for 8 cycles.
//    -> out_sel sequence is 0,1,2,3,0,1,2,3 and out_data matches each index.
// 4. Fixed priority, MODE=1: in_valid=1010 held for 3 cycles.
//    -> out_sel=1 on every beat; channel 3 is never granted.
// 5. Backpressure: all valid, out_ready=0 for 3 cycles, then 1.
//    -> While stalled, out_data and out_sel hold and in_ready=0000.
//    -> On release, the beat drains and the next channel loads in the same edge.
// 6. Mid-stream reset and non-power-of-2: N=3, all valid, rst pulsed for 1 cycle during streaming.
//    -> out_valid=0 on the next cycle; the sequence then restarts 0,1,2,0 (rr_ptr never reaches 3).

Source files
------------

// File: rtl/mux_rr_nto1_if.sv
// Handshake bundle for the N-to-1 registered mux.
// The producer/consumer side drives through master; the mux itself uses slave.
interface mux_rr_nto1_if #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int SEL_W = $clog2(N)
) ();
    logic [N-1:0]       in_valid;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [SEL_W-1:0]   out_sel;
    logic               out_ready;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_sel
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_sel
    );
endinterface

// File: rtl/mux_rr_nto1.sv
// N-to-1 registered mux, round-robin or fixed-priority arbitration.
// Each accepted beat lands in a one-deep output register.
module mux_rr_nto1 #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int MODE  = 0,
    parameter int SEL_W = $clog2(N)
) (
    input logic          clk,
    input logic          rst,
    mux_rr_nto1_if.slave bus
);
    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] base;
    logic [SEL_W-1:0] gnt_idx;
    logic             gnt_vld;
    logic [WIDTH-1:0] gnt_data;
    logic             load;
    logic [N-1:0]     ready_d;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic [SEL_W-1:0] out_sel_q;

    assign base = (MODE == 0) ? rr_ptr : '0;
    assign load = !out_valid_q || bus.out_ready;

    // Two passes: channels at or above base first, then the wrapped ones.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        gnt_data = '0;
        for (int i = 0; i < N; i++) begin
            if (!gnt_vld && bus.in_valid[i] && (SEL_W'(i) >= base)) begin
                gnt_vld  = 1'b1;
                gnt_idx  = SEL_W'(i);
                gnt_data = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!gnt_vld && bus.in_valid[i]) begin
                gnt_vld  = 1'b1;
                gnt_idx  = SEL_W'(i);
                gnt_data = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        ready_d = '0;
        for (int i = 0; i < N; i++) begin
            ready_d[i] = load && gnt_vld && !rst &&
                         (gnt_idx == SEL_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            rr_ptr      <= '0;
        end else if (load) begin
            out_valid_q <= gnt_vld;
            if (gnt_vld) begin
                out_data_q <= gnt_data;
                out_sel_q  <= gnt_idx;
                if (MODE == 0) begin
                    rr_ptr <= (gnt_idx == SEL_W'(N - 1)) ?
                              '0 : gnt_idx + SEL_W'(1);
                end
            end
        end
    end

    assign bus.in_ready  = ready_d;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;
endmodule

// File: tb/tb_mux_rr_nto1.sv
// Scoreboard bench for mux_rr_nto1: round-robin N=4, fixed-priority N=4,
// and round-robin N=3 instances driven with directed vectors.
module tb_mux_rr_nto1;
    logic clk = 1'b0;
    logic rst;
    logic rst2;

    always #5 clk = ~clk;

    mux_rr_nto1_if #(.N(4), .WIDTH(8)) b0 ();
    mux_rr_nto1_if #(.N(4), .WIDTH(8)) b1 ();
    mux_rr_nto1_if #(.N(3), .WIDTH(8)) b2 ();

    mux_rr_nto1 #(.N(4), .WIDTH(8), .MODE(0)) u0 (
        .clk(clk), .rst(rst), .bus(b0));
    mux_rr_nto1 #(.N(4), .WIDTH(8), .MODE(1)) u1 (
        .clk(clk), .rst(rst), .bus(b1));
    mux_rr_nto1 #(.N(3), .WIDTH(8), .MODE(0)) u2 (
        .clk(clk), .rst(rst2), .bus(b2));

    localparam logic [31:0] D4 = 32'h13121110;
    localparam logic [23:0] D3 = 24'h121110;

    int n_vec = 0;
    int n_bad = 0;
    logic [9:0] q0[$];
    logic [9:0] q1[$];
    logic [9:0] q2[$];
    logic [9:0] e0, e1, e2;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: a beat is consumed whenever out_valid && out_ready outside reset.
    always @(negedge clk) begin
        if (b0.out_valid && b0.out_ready && !rst) begin
            if (q0.size() == 0) begin
                chk("u0 unexpected beat", {22'd0, b0.out_sel, b0.out_data}, 32'h3ff);
            end else begin
                e0 = q0.pop_front();
                chk("u0 beat sel/data", {22'd0, b0.out_sel, b0.out_data}, {22'd0, e0});
            end
        end
        if (b1.out_valid && b1.out_ready && !rst) begin
            if (q1.size() == 0) begin
                chk("u1 unexpected beat", {22'd0, b1.out_sel, b1.out_data}, 32'h3ff);
            end else begin
                e1 = q1.pop_front();
                chk("u1 beat sel/data", {22'd0, b1.out_sel, b1.out_data}, {22'd0, e1});
            end
        end
        if (b2.out_valid && b2.out_ready && !rst2) begin
            if (q2.size() == 0) begin
                chk("u2 unexpected beat", {22'd0, b2.out_sel, b2.out_data}, 32'h3ff);
            end else begin
                e2 = q2.pop_front();
                chk("u2 beat sel/data", {22'd0, b2.out_sel, b2.out_data}, {22'd0, e2});
            end
        end
    end

    initial begin
        rst  = 1'b1;
        rst2 = 1'b1;
        b0.in_valid = 4'hF; b0.in_data = D4; b0.out_ready = 1'b1;
        b1.in_valid = 4'hF; b1.in_data = D4; b1.out_ready = 1'b1;
        b2.in_valid = 3'h7; b2.in_data = D3; b2.out_ready = 1'b1;

        // reset held two cycles with every channel valid
        tick;
        @(negedge clk);
        chk("rst u0 out_valid", {31'd0, b0.out_valid}, 32'd0);
        chk("rst u0 out_data", {24'd0, b0.out_data}, 32'd0);
        chk("rst u0 out_sel", {30'd0, b0.out_sel}, 32'd0);
        chk("rst u0 in_ready", {28'd0, b0.in_ready}, 32'd0);
        chk("rst u1 in_ready", {28'd0, b1.in_ready}, 32'd0);
        chk("rst u2 in_ready", {29'd0, b2.in_ready}, 32'd0);
        chk("rst u2 out_valid", {31'd0, b2.out_valid}, 32'd0);
        tick;
        rst  = 1'b0;
        rst2 = 1'b0;
        b1.in_valid = 4'h0;
        b2.in_valid = 3'h0;

        // round-robin streaming, 8 transfers
        q0.push_back({2'd0, 8'h10}); q0.push_back({2'd1, 8'h11});
        q0.push_back({2'd2, 8'h12}); q0.push_back({2'd3, 8'h13});
        q0.push_back({2'd0, 8'h10}); q0.push_back({2'd1, 8'h11});
        q0.push_back({2'd2, 8'h12}); q0.push_back({2'd3, 8'h13});
        @(negedge clk);
        chk("u0 first grant", {28'd0, b0.in_ready}, 32'b0001);
        repeat (8) tick;
        b0.in_valid = 4'h0;
        repeat (2) tick;
        @(negedge clk);
        chk("u0 idle out_valid", {31'd0, b0.out_valid}, 32'd0);

        // single channel
        tick;
        b0.in_data = 32'h13A51110;
        b0.in_valid = 4'b0100;
        q0.push_back({2'd2, 8'hA5});
        @(negedge clk);
        chk("u0 single in_ready", {28'd0, b0.in_ready}, 32'b0100);
        tick;
        b0.in_valid = 4'h0;
        b0.in_data = D4;
        @(negedge clk);
        chk("u0 single out_valid", {31'd0, b0.out_valid}, 32'd1);
        repeat (2) tick;

        // backpressure: rr_ptr now 3
        b0.out_ready = 1'b0;
        b0.in_valid = 4'hF;
        q0.push_back({2'd3, 8'h13});
        tick;
        repeat (3) begin
            @(negedge clk);
            chk("u0 stall in_ready", {28'd0, b0.in_ready}, 32'd0);
            chk("u0 stall out_valid", {31'd0, b0.out_valid}, 32'd1);
            chk("u0 stall out_sel", {30'd0, b0.out_sel}, 32'd3);
            chk("u0 stall out_data", {24'd0, b0.out_data}, 32'h13);
            tick;
        end
        b0.out_ready = 1'b1;
        q0.push_back({2'd0, 8'h10});
        @(negedge clk);
        chk("u0 release in_ready", {28'd0, b0.in_ready}, 32'b0001);
        tick;
        b0.in_valid = 4'h0;
        @(negedge clk);
        chk("u0 refill no bubble", {31'd0, b0.out_valid}, 32'd1);
        repeat (2) tick;

        // fixed priority
        b1.in_valid = 4'b1010;
        repeat (3) q1.push_back({2'd1, 8'h11});
        repeat (3) begin
            @(negedge clk);
            chk("u1 prio in_ready", {28'd0, b1.in_ready}, 32'b0010);
            tick;
        end
        b1.in_valid = 4'h0;
        repeat (2) tick;

        // N=3 with a reset pulse mid-stream
        b2.in_valid = 3'h7;
        q2.push_back({2'd0, 8'h10});
        @(negedge clk);
        chk("u2 first grant", {29'd0, b2.in_ready}, 32'b001);
        tick;
        tick;
        rst2 = 1'b1;
        @(negedge clk);
        chk("u2 rst in_ready", {29'd0, b2.in_ready}, 32'd0);
        tick;
        rst2 = 1'b0;
        q2.push_back({2'd0, 8'h10}); q2.push_back({2'd1, 8'h11});
        q2.push_back({2'd2, 8'h12}); q2.push_back({2'd0, 8'h10});
        @(negedge clk);
        chk("u2 post-rst out_valid", {31'd0, b2.out_valid}, 32'd0);
        chk("u2 post-rst in_ready", {29'd0, b2.in_ready}, 32'b001);
        repeat (4) tick;
        b2.in_valid = 3'h0;
        repeat (3) tick;

        chk("u0 queue drained", q0.size(), 32'd0);
        chk("u1 queue drained", q1.size(), 32'd0);
        chk("u2 queue drained", q2.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
